// File: rtl/f1_start_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : f1_start_sequencer_if                                 |
// | Description : Control and light bus between the start sequencer     |
// |               and its environment (tick divider, LFSR/delay block,  |
// |               board LEDs).                                          |
// | Revision    : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
interface f1_start_sequencer_if #(
   parameter int NUM_LIGHTS = 10,
   parameter int RT_W       = 12
);
   // Inputs to the sequencer
   logic                  tick;
   logic                  trigger;
   logic                  time_out;
   logic                  abort;
   logic                  driver_press;
   // Outputs from the sequencer
   logic [NUM_LIGHTS-1:0] ledr;
   logic                  en_lfsr;
   logic                  start_delay;
   logic                  lights_out;
   logic                  jump_start;
   logic                  busy;
   logic [RT_W-1:0]       reaction;
   logic                  reaction_valid;

   // Environment side: drives the strobes, observes the lights
   modport master (
      output tick, trigger, time_out, abort, driver_press,
      input  ledr, en_lfsr, start_delay, lights_out, jump_start, busy,
             reaction, reaction_valid
   );

   // Sequencer side
   modport slave (
      input  tick, trigger, time_out, abort, driver_press,
      output ledr, en_lfsr, start_delay, lights_out, jump_start, busy,
             reaction, reaction_valid
   );
endinterface
`default_nettype wire

// File: rtl/f1_start_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : f1_start_sequencer                                    |
// | Description : Start-light sequencer. Lights NUM_LIGHTS LEDs one per |
// |               tick, requests a random hold, extinguishes on         |
// |               time_out. Detects jump starts (blinking FAULT) and    |
// |               supports abort.                                       |
// |               Optional reaction timer in GO, enabled by defining    |
// |               the macro F1_REACTION_TIMER_EN.                       |
// | Revision    : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
module f1_start_sequencer #(
   parameter int NUM_LIGHTS  = 10,
   parameter int BLINK_TICKS = 4,
   parameter int RT_W        = 12
) (
   input  wire                 sysclk,
   input  wire                 rst_n,
   f1_start_sequencer_if.slave seq
);

   localparam int CNT_W   = $clog2(NUM_LIGHTS + 1);
   localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

   localparam logic [CNT_W-1:0]      CNT_FULL    = CNT_W'(NUM_LIGHTS);
   localparam logic [BLINK_W-1:0]    BLINK_LAST  = BLINK_W'(BLINK_TICKS - 1);
   // Leftmost light; shifted right by the lit count to get the next light
   localparam logic [NUM_LIGHTS-1:0] FIRST_LIGHT = {1'b1, {(NUM_LIGHTS-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      COUNT = 3'd1,
      HOLD  = 3'd2,
      GO    = 3'd3,
      FAULT = 3'd4
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [CNT_W-1:0]        count;
   logic [CNT_W-1:0]        count_next;
   logic [NUM_LIGHTS-1:0]   lights;
   logic [NUM_LIGHTS-1:0]   lights_next;
   logic [BLINK_W-1:0]      blink_cnt;
   logic [BLINK_W-1:0]      blink_next;
   logic                    start_pulse;
   logic                    start_pulse_next;
   logic                    out_pulse;
   logic                    out_pulse_next;
   logic                    fault_flag;
   logic                    busy_flag;
   logic                    lfsr_run;

`ifdef F1_REACTION_TIMER_EN
   logic [RT_W-1:0]         rt_cnt;
   logic [RT_W-1:0]         rt_next;
   logic [RT_W-1:0]         reaction;
   logic [RT_W-1:0]         reaction_next;
   logic                    react_pulse;
   logic                    react_pulse_next;
`endif

   // Next-state and next-output decode; abort beats a press, a press beats
   // tick/time_out/trigger
   always_comb begin
      state_next       = state;
      count_next       = count;
      lights_next      = lights;
      blink_next       = blink_cnt;
      start_pulse_next = 1'b0;
      out_pulse_next   = 1'b0;
`ifdef F1_REACTION_TIMER_EN
      rt_next          = rt_cnt;
      reaction_next    = reaction;
      react_pulse_next = 1'b0;
`endif
      if (seq.abort) begin
         state_next  = IDLE;
         count_next  = '0;
         lights_next = '0;
         blink_next  = '0;
      end else begin
         case (state)
            IDLE: begin
               count_next  = '0;
               lights_next = '0;
               if (seq.trigger) begin
                  state_next = COUNT;
               end
            end
            COUNT: begin
               if (seq.driver_press) begin
                  state_next  = FAULT;
                  lights_next = '1;
                  blink_next  = '0;
               end else if (count == CNT_FULL) begin
                  state_next       = HOLD;
                  start_pulse_next = 1'b1;
               end else if (seq.tick) begin
                  lights_next = lights | (FIRST_LIGHT >> count);
                  count_next  = count + 1'b1;
               end
            end
            HOLD: begin
               // start_pulse is high only on the first HOLD cycle; a time_out
               // level left over from before the hold is ignored then
               if (seq.driver_press) begin
                  state_next  = FAULT;
                  lights_next = '1;
                  blink_next  = '0;
               end else if (seq.time_out && !start_pulse) begin
                  state_next     = GO;
                  lights_next    = '0;
                  out_pulse_next = 1'b1;
`ifdef F1_REACTION_TIMER_EN
                  rt_next        = '0;
`endif
               end
            end
            GO: begin
`ifdef F1_REACTION_TIMER_EN
               // The register value is captured, so a tick in the press
               // cycle does not count and a press on entry yields zero
               if (seq.driver_press) begin
                  reaction_next    = rt_cnt;
                  react_pulse_next = 1'b1;
                  state_next       = IDLE;
               end else if (seq.tick && (rt_cnt != {RT_W{1'b1}})) begin
                  rt_next = rt_cnt + 1'b1;
               end
`else
               state_next = IDLE;
`endif
            end
            FAULT: begin
               if (seq.tick) begin
                  if (blink_cnt == BLINK_LAST) begin
                     lights_next = ~lights;
                     blink_next  = '0;
                  end else begin
                     blink_next = blink_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state_next  = IDLE;
               count_next  = '0;
               lights_next = '0;
               blink_next  = '0;
            end
         endcase
      end
   end

   // State and registered outputs; level outputs follow the next state
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         count       <= '0;
         lights      <= '0;
         blink_cnt   <= '0;
         start_pulse <= 1'b0;
         out_pulse   <= 1'b0;
         fault_flag  <= 1'b0;
         busy_flag   <= 1'b0;
         lfsr_run    <= 1'b1;
      end else begin
         state       <= state_next;
         count       <= count_next;
         lights      <= lights_next;
         blink_cnt   <= blink_next;
         start_pulse <= start_pulse_next;
         out_pulse   <= out_pulse_next;
         fault_flag  <= (state_next == FAULT);
         busy_flag   <= (state_next != IDLE);
         lfsr_run    <= (state_next != HOLD);
      end
   end

`ifdef F1_REACTION_TIMER_EN
   // Reaction counter and captured result; the result survives abort
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         rt_cnt      <= '0;
         reaction    <= '0;
         react_pulse <= 1'b0;
      end else begin
         rt_cnt      <= rt_next;
         reaction    <= reaction_next;
         react_pulse <= react_pulse_next;
      end
   end

   assign seq.reaction       = reaction;
   assign seq.reaction_valid = react_pulse;
`else
   assign seq.reaction       = '0;
   assign seq.reaction_valid = 1'b0;
`endif

   assign seq.ledr        = lights;
   assign seq.en_lfsr     = lfsr_run;
   assign seq.start_delay = start_pulse;
   assign seq.lights_out  = out_pulse;
   assign seq.jump_start  = fault_flag;
   assign seq.busy        = busy_flag;

endmodule
`default_nettype wire

// File: tb/tb_f1_start_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_f1_start_sequencer                                 |
// | Description : Self-checking bench for f1_start_sequencer with a     |
// |               behavioural model compared every cycle plus directed  |
// |               literal checks. Honours F1_REACTION_TIMER_EN.         |
// | Revision    : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
module tb_f1_start_sequencer;

   localparam int NL = 10;
   localparam int BT = 4;
`ifdef F1_REACTION_TIMER_EN
   localparam int RW = 4;
`else
   localparam int RW = 12;
`endif

   logic sysclk = 1'b0;
   logic rst_n  = 1'b0;

   f1_start_sequencer_if #(.NUM_LIGHTS(NL), .RT_W(RW)) bus ();

   f1_start_sequencer #(
      .NUM_LIGHTS (NL),
      .BLINK_TICKS(BT),
      .RT_W       (RW)
   ) dut (
      .sysclk(sysclk),
      .rst_n (rst_n),
      .seq   (bus.slave)
   );

   always #5 sysclk = ~sysclk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Top n lights lit, counted from the leftmost
   function automatic logic [31:0] lit_pattern(input int n);
      logic [31:0] p;
      p = (32'd1 << n) - 32'd1;
      return p << (NL - n);
   endfunction

   // ---------------- behavioural model ----------------
   // phase: 0 idle, 1 lighting, 2 holding, 3 go, 4 fault
   int m_phase       = 0;
   int m_lit         = 0;
   int m_hold_age    = 0;
   int m_fault_ticks = 0;
   int m_go_ticks    = 0;
   int m_react       = 0;
   bit m_sd = 1'b0, m_lo = 1'b0, m_rv = 1'b0;

   always @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0; m_lit = 0; m_react = 0;
         m_sd = 1'b0; m_lo = 1'b0; m_rv = 1'b0;
      end else begin
         m_sd = 1'b0; m_lo = 1'b0; m_rv = 1'b0;
         if (bus.abort) begin
            m_phase = 0; m_lit = 0;
         end else begin
            case (m_phase)
               0: if (bus.trigger) begin m_phase = 1; m_lit = 0; end
               1: if (bus.driver_press) begin m_phase = 4; m_fault_ticks = 0; end
                  else if (m_lit == NL) begin m_phase = 2; m_hold_age = 0; m_sd = 1'b1; end
                  else if (bus.tick) m_lit++;
               2: if (bus.driver_press) begin m_phase = 4; m_fault_ticks = 0; end
                  else if (bus.time_out && m_hold_age > 0) begin
                     m_phase = 3; m_go_ticks = 0; m_lo = 1'b1;
                  end else m_hold_age++;
               3: begin
`ifdef F1_REACTION_TIMER_EN
                  if (bus.driver_press) begin
                     m_react = (m_go_ticks > (2**RW - 1)) ? (2**RW - 1) : m_go_ticks;
                     m_rv = 1'b1; m_phase = 0;
                  end else if (bus.tick) m_go_ticks++;
`else
                  m_phase = 0;
`endif
               end
               4: if (bus.tick) m_fault_ticks++;
               default: m_phase = 0;
            endcase
         end
      end
   end

   function automatic logic [31:0] m_ledr();
      if (m_phase == 1 || m_phase == 2) return lit_pattern(m_lit);
      if (m_phase == 4) return (((m_fault_ticks / BT) % 2) == 0) ? lit_pattern(NL) : 32'd0;
      return 32'd0;
   endfunction

   // Every-cycle comparison against the model
   always @(negedge sysclk) begin
      chk("ledr",           32'(bus.ledr),           m_ledr());
      chk("en_lfsr",        32'(bus.en_lfsr),        32'(m_phase != 2));
      chk("busy",           32'(bus.busy),           32'(m_phase != 0));
      chk("jump_start",     32'(bus.jump_start),     32'(m_phase == 4));
      chk("start_delay",    32'(bus.start_delay),    32'(m_sd));
      chk("lights_out",     32'(bus.lights_out),     32'(m_lo));
      chk("reaction",       32'(bus.reaction),       32'(m_react));
      chk("reaction_valid", 32'(bus.reaction_valid), 32'(m_rv));
   end

   // ---------------- stimulus ----------------
   bit tick_en = 1'b0;
   bit ticked  = 1'b0;
   int cyc     = 0;

   task automatic step();
      @(posedge sysclk);
      #2;
      ticked   = bus.tick;
      cyc++;
      bus.tick = tick_en && ((cyc % 4) == 0);
   endtask

   task automatic pulse_trigger();
      bus.trigger = 1'b1;
      step();
      bus.trigger = 1'b0;
   endtask

   task automatic wait_ledr(input logic [31:0] v, input string name, output int steps);
      steps = 0;
      while (32'(bus.ledr) != v && steps < 40) begin
         step();
         steps++;
      end
      chk(name, 32'(bus.ledr), v);
   endtask

   task automatic wait_sd(output int steps);
      steps = 0;
      while (!bus.start_delay && steps < 80) begin
         step();
         steps++;
      end
      chk("start_delay_seen", 32'(bus.start_delay), 32'd1);
   endtask

`ifdef F1_REACTION_TIMER_EN
   task automatic go_press(input int nticks, input logic [31:0] exp_r);
      int t = 0;
      for (int i = 0; i < 400 && t < nticks; i++) begin
         step();
         if (ticked) t++;
      end
      chk("go_tick_budget", 32'(t), 32'(nticks));
      bus.driver_press = 1'b1;
      step();
      bus.driver_press = 1'b0;
      chk("reaction_value", 32'(bus.reaction), exp_r);
      chk("reaction_valid_hi", 32'(bus.reaction_valid), 32'd1);
      step();
      chk("reaction_valid_lo", 32'(bus.reaction_valid), 32'd0);
      chk("reaction_kept", 32'(bus.reaction), exp_r);
   endtask
`endif

   initial begin
      int n;
      bit lo_seen;
      bus.tick = 1'b0; bus.trigger = 1'b0; bus.time_out = 1'b0;
      bus.abort = 1'b0; bus.driver_press = 1'b0;
      rst_n = 1'b0;
      repeat (3) step();
      chk("rst_ledr",    32'(bus.ledr),        32'd0);
      chk("rst_en_lfsr", 32'(bus.en_lfsr),     32'd1);
      chk("rst_busy",    32'(bus.busy),        32'd0);
      chk("rst_sd",      32'(bus.start_delay), 32'd0);
      chk("rst_js",      32'(bus.jump_start),  32'd0);
      rst_n   = 1'b1;
      tick_en = 1'b1;
      step();

      // Full light sequence, hold, lights out
      pulse_trigger();
      for (int k = 1; k <= NL; k++) wait_ledr(lit_pattern(k), "light_seq", n);
      wait_sd(n);
      chk("sd_latency", 32'(n), 32'd1);
      chk("hold_en_lfsr", 32'(bus.en_lfsr), 32'd0);
      step();
      chk("sd_single", 32'(bus.start_delay), 32'd0);
      chk("hold_en_lfsr2", 32'(bus.en_lfsr), 32'd0);
      repeat (3) step();
      bus.time_out = 1'b1;
      step();
      bus.time_out = 1'b0;
      chk("lights_out_pulse", 32'(bus.lights_out), 32'd1);
      chk("go_ledr", 32'(bus.ledr), 32'd0);
`ifdef F1_REACTION_TIMER_EN
      go_press(7, 32'd7);
`else
      step();
      chk("go_one_cycle", 32'(bus.busy), 32'd0);
`endif

      // time_out held before HOLD: stale level ignored on first HOLD cycle
      step();
      pulse_trigger();
      wait_ledr(lit_pattern(6), "pre_hold", n);
      bus.time_out = 1'b1;
      wait_sd(n);
      step();
      chk("stale_guard_lo", 32'(bus.lights_out), 32'd0);
      chk("stale_guard_ledr", 32'(bus.ledr), 32'h3FF);
      step();
      bus.time_out = 1'b0;
      chk("second_hold_lo", 32'(bus.lights_out), 32'd1);
      chk("second_hold_ledr", 32'(bus.ledr), 32'd0);
`ifdef F1_REACTION_TIMER_EN
      go_press(20, 32'd15);
`else
      step();
`endif

      // Jump start after three lights, blink, abort
      step();
      pulse_trigger();
      wait_ledr(lit_pattern(3), "three_lit", n);
      bus.driver_press = 1'b1;
      step();
      bus.driver_press = 1'b0;
      chk("fault_js", 32'(bus.jump_start), 32'd1);
      chk("fault_ledr", 32'(bus.ledr), 32'h3FF);
      bus.trigger  = 1'b1;
      bus.time_out = 1'b1;
      wait_ledr(32'd0, "blink_off", n);
      wait_ledr(32'h3FF, "blink_on", n);
      chk("blink_period", 32'(n), 32'd16);
      chk("fault_sticky", 32'(bus.jump_start), 32'd1);
      bus.abort = 1'b1; bus.trigger = 1'b0; bus.time_out = 1'b0;
      step();
      bus.abort = 1'b0;
      chk("abort_ledr", 32'(bus.ledr), 32'd0);
      chk("abort_js", 32'(bus.jump_start), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);

      // Press and time_out in the same HOLD cycle: press wins
      step();
      pulse_trigger();
      wait_sd(n);
      step();
      bus.time_out = 1'b1; bus.driver_press = 1'b1;
      step();
      bus.time_out = 1'b0; bus.driver_press = 1'b0;
      chk("tie_js", 32'(bus.jump_start), 32'd1);
      lo_seen = bus.lights_out;
      repeat (5) begin step(); lo_seen |= bus.lights_out; end
      chk("tie_no_lights_out", 32'(lo_seen), 32'd0);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;

      // Trigger held high: re-arms after one idle cycle
      bus.trigger = 1'b1;
      step();
      wait_sd(n);
      bus.time_out = 1'b1;
      step();
      step();
      bus.time_out = 1'b0;
      chk("rearm_lo", 32'(bus.lights_out), 32'd1);
`ifdef F1_REACTION_TIMER_EN
      bus.driver_press = 1'b1;
      step();
      bus.driver_press = 1'b0;
      chk("react_on_entry", 32'(bus.reaction), 32'd0);
      chk("react_on_entry_v", 32'(bus.reaction_valid), 32'd1);
`else
      step();
`endif
      chk("rearm_idle", 32'(bus.busy), 32'd0);
      step();
      chk("rearm_count", 32'(bus.busy), 32'd1);
      bus.trigger = 1'b0;
      bus.abort   = 1'b1;
      step();
      bus.abort   = 1'b0;

      // Asynchronous reset with five lights lit
      step();
      pulse_trigger();
      wait_ledr(lit_pattern(5), "five_lit", n);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_ledr", 32'(bus.ledr), 32'd0);
      chk("async_rst_busy", 32'(bus.busy), 32'd0);
      chk("async_rst_en", 32'(bus.en_lfsr), 32'd1);
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_idle", 32'(bus.busy), 32'd0);
      repeat (2) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
